// File: rtl/jtcontra_gfx_pkg.sv
// Shared types and helpers for the jtcontra tilemap renderer.
//   state_t      : line walker FSM states
//   ATTR_*       : bit positions inside the tile attribute byte
//   ppw_f/wb_f   : pixels per 16-bit ROM word, ROM word-index width per tile row
package jtcontra_gfx_pkg;

    typedef enum logic [2:0] {IDLE, SCR, VN, MAP, ROMW, DUMP, NEXT} state_t;

    localparam int ATTR_HFLIP = 4;
    localparam int ATTR_VFLIP = 5;
    localparam int ATTR_PRIO  = 6;

    function automatic int ppw_f(input int bpp);
        return 16 / bpp;
    endfunction

    function automatic int wb_f(input int tile_bits, input int bpp);
        return tile_bits - $clog2(16 / bpp);
    endfunction

endpackage

// File: rtl/jtcontra_gfx_tilemap_gen_if.sv
// Graphics ROM request bus of the tilemap renderer.
//   rom_cs   : request, held until rom_ok
//   rom_addr : {code, vrow, hword}
//   rom_ok   : rom_data valid this cycle
//   rom_data : 16-bit graphics word, leftmost pixel in the MSBs
interface jtcontra_gfx_tilemap_gen_if #(parameter int ROM_AW = 17);
    logic              rom_cs;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_ok;
    logic [15:0]       rom_data;

    modport master (output rom_cs, rom_addr, input  rom_ok, rom_data);
    modport slave  (input  rom_cs, rom_addr, output rom_ok, rom_data);
endinterface

// File: rtl/jtcontra_gfx_pxlshift.sv
// Pixel serialiser for one 16-bit graphics word.
//   load_i  : capture data_i and arm the pixel counter
//   shift_i : advance one pixel
//   hflip_i : 0 = MSB-first, 1 = LSB-first
//   pxl_o   : current pixel, last_o : current pixel is the final one of the word
module jtcontra_gfx_pxlshift
    import jtcontra_gfx_pkg::*;
#(
    parameter int BPP = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           shift_i,
    input  logic           hflip_i,
    input  logic [15:0]    data_i,
    output logic [BPP-1:0] pxl_o,
    output logic           last_o
);
    localparam int PPW = ppw_f(BPP);
    localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;

    logic [15:0]   data_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            cnt_q  <= CW'(PPW - 1);
        end else if (shift_i) begin
            data_q <= hflip_i ? (data_q >> BPP) : (data_q << BPP);
            cnt_q  <= cnt_q - 1'b1;
        end
    end

    assign pxl_o  = hflip_i ? data_q[BPP-1:0] : data_q[15 -: BPP];
    assign last_o = (cnt_q == '0);
endmodule

// File: rtl/jtcontra_gfx_tilemap_gen.sv
// Per-line tilemap renderer. On an active HS edge it walks one scanline of the
// tile map, fetches graphics words from ROM and writes palette-tagged pixels
// into the half of the line buffer selected by 'line'.
// Optional build macro: JTCONTRA_TMAP_PRIO_EN adds the tile priority bit as
// the MSB of line_din.
// Ports: clk/rst (sync, active-high); HS/LVBL/vrender/flip timing; hscroll,
// vscroll, rowscr_en, colscr_en scroll control; scr_addr/scr_data scroll RAM;
// scan_addr/code_scan/attr_scan tile map; rom (ROM bus interface);
// line/line_we/line_addr/line_din line buffer write port; done status.
module jtcontra_gfx_tilemap_gen
    import jtcontra_gfx_pkg::*;
#(
    parameter int         TILE_BITS  = 3,
    parameter int         BPP        = 4,
    parameter int         CODE_W     = 13,
    parameter int         PAL_W      = 4,
    parameter int         MAP_W      = 5,
    parameter logic [8:0] HEND       = 9'o500,
    parameter logic [8:0] DUMP_START = 9'd0,
    parameter logic [8:0] FLIP_OFS   = 9'h116,
    localparam int PPW    = ppw_f(BPP),
    localparam int LPPW   = $clog2(PPW),
    localparam int WB     = wb_f(TILE_BITS, BPP),
    localparam int ROM_AW = CODE_W + TILE_BITS + WB,
`ifdef JTCONTRA_TMAP_PRIO_EN
    localparam int DW     = PAL_W + BPP + 1
`else
    localparam int DW     = PAL_W + BPP
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HS,
    input  logic                  LVBL,
    input  logic [8:0]            vrender,
    input  logic                  flip,
    input  logic [8:0]            hscroll,
    input  logic [7:0]            vscroll,
    input  logic                  rowscr_en,
    input  logic                  colscr_en,
    output logic [MAP_W-1:0]      scr_addr,
    input  logic [8:0]            scr_data,
    output logic [2*MAP_W-1:0]    scan_addr,
    input  logic [CODE_W-1:0]     code_scan,
    input  logic [7:0]            attr_scan,
    jtcontra_gfx_tilemap_gen_if.master rom,
    output logic                  line,
    output logic                  line_we,
    output logic [9:0]            line_addr,
    output logic [DW-1:0]         line_din,
    output logic                  done
);
    localparam int TMASK = (1 << TILE_BITS) - 1;
    localparam int WMASK = (1 << WB) - 1;

    state_t              state_q;
    logic                ph_q;          // second cycle of SCR/VN/MAP: read data now valid
    logic                hs_q;
    logic [8:0]          hpos_q, vn_q, hrender_q;
    logic [CODE_W-1:0]   code_q;
    logic [PAL_W-1:0]    pal_q;
    logic                hflip_q, vflip_q;
    logic [MAP_W-1:0]    scr_addr_q;
    logic [2*MAP_W-1:0]  scan_addr_q;
    logic                rom_cs_q;
    logic [ROM_AW-1:0]   rom_addr_q;
    logic                line_q, line_we_q, done_q;
    logic [9:0]          line_addr_q;
    logic [DW-1:0]       line_din_q;
`ifdef JTCONTRA_TMAP_PRIO_EN
    logic                prio_q;
`endif

    logic                hs_edge;
    logic [8:0]          hpos_d, vn_d, hpos_nx;
    logic [BPP-1:0]      px;
    logic                px_last, px_load, px_shift;

    function automatic logic [ROM_AW-1:0] rom_addr_f(
        input logic [CODE_W-1:0] code, input logic [8:0] v, input logic [8:0] h,
        input logic hf, input logic vf);
        logic [ROM_AW-1:0] vr, hw;
        vr = ROM_AW'((v ^ {9{vf}}) & 9'(TMASK));
        hw = ROM_AW'(((h >> LPPW) ^ {9{hf}}) & 9'(WMASK));
        return (ROM_AW'(code) << (TILE_BITS + WB)) | (vr << WB) | hw;
    endfunction

    assign hs_edge = HS & ~hs_q & LVBL;
    assign hpos_d  = rowscr_en ? scr_data : hscroll;
    assign vn_d    = (vrender ^ {9{flip}}) + {1'b0, colscr_en ? scr_data[7:0] : vscroll};
    assign hpos_nx = hpos_q + 9'(PPW);

    // An HS restart overrides whatever the shifter would have done this cycle.
    assign px_load  = (state_q == ROMW) && rom.rom_ok && !hs_edge;
    assign px_shift = (state_q == DUMP) && !hs_edge;

    jtcontra_gfx_pxlshift #(.BPP(BPP)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (px_load),
        .shift_i (px_shift),
        .hflip_i (hflip_q),
        .data_i  (rom.rom_data),
        .pxl_o   (px),
        .last_o  (px_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ph_q        <= 1'b0;
            hs_q        <= 1'b0;
            hpos_q      <= '0;
            vn_q        <= '0;
            hrender_q   <= DUMP_START;
            code_q      <= '0;
            pal_q       <= '0;
            hflip_q     <= 1'b0;
            vflip_q     <= 1'b0;
            scr_addr_q  <= '0;
            scan_addr_q <= '0;
            rom_cs_q    <= 1'b0;
            rom_addr_q  <= '0;
            line_q      <= 1'b0;
            line_we_q   <= 1'b0;
            line_addr_q <= '0;
            line_din_q  <= '0;
            done_q      <= 1'b1;
`ifdef JTCONTRA_TMAP_PRIO_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            hs_q <= HS;
            if (hs_edge) begin
                // Valid in every state: a mid-line edge abandons the current line.
                line_q     <= ~line_q;
                done_q     <= 1'b0;
                rom_cs_q   <= 1'b0;
                line_we_q  <= 1'b0;
                scr_addr_q <= vrender[TILE_BITS +: MAP_W];
                ph_q       <= 1'b0;
                state_q    <= SCR;
            end else begin
                case (state_q)
                    IDLE: ;
                    SCR: if (!ph_q) ph_q <= 1'b1; else begin
                        hpos_q     <= hpos_d;
                        // Fine scroll: start left of DUMP_START so the word stays aligned.
                        hrender_q  <= DUMP_START - (hpos_d & 9'(PPW - 1));
                        scr_addr_q <= hpos_d[TILE_BITS +: MAP_W];
                        ph_q       <= 1'b0;
                        state_q    <= VN;
                    end
                    VN: if (!ph_q) ph_q <= 1'b1; else begin
                        vn_q        <= vn_d;
                        scan_addr_q <= {vn_d[TILE_BITS +: MAP_W], hpos_q[TILE_BITS +: MAP_W]};
                        ph_q        <= 1'b0;
                        state_q     <= MAP;
                    end
                    MAP: if (!ph_q) ph_q <= 1'b1; else begin
                        code_q     <= code_scan;
                        pal_q      <= attr_scan[PAL_W-1:0];
                        hflip_q    <= attr_scan[ATTR_HFLIP];
                        vflip_q    <= attr_scan[ATTR_VFLIP];
`ifdef JTCONTRA_TMAP_PRIO_EN
                        prio_q     <= attr_scan[ATTR_PRIO];
`endif
                        rom_cs_q   <= 1'b1;
                        rom_addr_q <= rom_addr_f(code_scan, vn_q, hpos_q,
                                                 attr_scan[ATTR_HFLIP], attr_scan[ATTR_VFLIP]);
                        ph_q       <= 1'b0;
                        state_q    <= ROMW;
                    end
                    ROMW: if (rom.rom_ok) begin
                        rom_cs_q <= 1'b0;
                        state_q  <= DUMP;
                    end
                    DUMP: begin
                        line_we_q   <= 1'b1;
                        line_addr_q <= {line_q, flip ? FLIP_OFS - hrender_q : hrender_q};
`ifdef JTCONTRA_TMAP_PRIO_EN
                        line_din_q  <= {prio_q, pal_q, px};
`else
                        line_din_q  <= {pal_q, px};
`endif
                        hrender_q   <= hrender_q + 9'd1;
                        if (px_last) state_q <= NEXT;
                    end
                    NEXT: begin
                        line_we_q <= 1'b0;
                        if (hrender_q >= HEND) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            hpos_q <= hpos_nx;
                            if (((hpos_nx >> LPPW) & 9'(WMASK)) != 9'd0) begin
                                // Same tile row, next word: no map/scroll lookup needed.
                                rom_cs_q   <= 1'b1;
                                rom_addr_q <= rom_addr_f(code_q, vn_q, hpos_nx, hflip_q, vflip_q);
                                state_q    <= ROMW;
                            end else begin
                                scr_addr_q <= hpos_nx[TILE_BITS +: MAP_W];
                                state_q    <= VN;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign scr_addr     = scr_addr_q;
    assign scan_addr    = scan_addr_q;
    assign rom.rom_cs   = rom_cs_q;
    assign rom.rom_addr = rom_addr_q;
    assign line         = line_q;
    assign line_we      = line_we_q;
    assign line_addr    = line_addr_q;
    assign line_din     = line_din_q;
    assign done         = done_q;

    logic unused_ok;
    assign unused_ok = ^{attr_scan, vn_q, hpos_q};
endmodule
